// File: rtl/mem_arb_pkg.sv
// Shared types for the memory channel arbiter.
// Channel FSM state encoding and consumer-index width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELEASE    = 2'd3
  } ch_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_channel.sv
// One memory channel: owns a single consumer transaction at a time.
// Write path built only when MEM_ARB_WRITE_EN is defined.
module mem_arb_channel
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int IW        = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic [IW-1:0]        grant_idx,
  input  logic                 grant_write,
  input  logic [ADDR_BITS-1:0] grant_addr,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 cons_valid,
  input  logic                 mem_read_ready,
  input  logic                 mem_write_ready,
  output logic                 idle,
  output logic [IW-1:0]        cur_idx,
  output logic                 cur_write,
  output logic                 rd_done,
  output logic                 wr_done,
  output logic                 release_pulse,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data
);

  ch_state_t state;
  logic      go_write;

`ifdef MEM_ARB_WRITE_EN
  logic                 wv;
  logic [ADDR_BITS-1:0] wa;
  logic [DATA_BITS-1:0] wd;
  assign go_write          = grant_write;
  assign mem_write_valid   = wv;
  assign mem_write_address = wa;
  assign mem_write_data    = wd;
  assign wr_done = (state == WRITE_WAIT) && mem_write_ready;
`else
  logic unused_wr;
  assign go_write          = 1'b0;
  assign mem_write_valid   = 1'b0;
  assign mem_write_address = '0;
  assign mem_write_data    = '0;
  assign wr_done           = 1'b0;
  assign unused_wr = ^{grant_write, grant_data, mem_write_ready};
`endif

  assign idle    = (state == IDLE);
  assign rd_done = (state == READ_WAIT) && mem_read_ready;
  assign release_pulse = (state == RELEASE) && !cons_valid;

  // Channel FSM with registered memory-side request outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cur_idx          <= '0;
      cur_write        <= 1'b0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
`ifdef MEM_ARB_WRITE_EN
      wv <= 1'b0;
      wa <= '0;
      wd <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            cur_idx   <= grant_idx;
            cur_write <= go_write;
            if (go_write) begin
              state <= WRITE_WAIT;
`ifdef MEM_ARB_WRITE_EN
              wv <= 1'b1;
              wa <= grant_addr;
              wd <= grant_data;
`endif
            end else begin
              state            <= READ_WAIT;
              mem_read_valid   <= 1'b1;
              mem_read_address <= grant_addr;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid <= 1'b0;
            state          <= RELEASE;
          end
        end
        WRITE_WAIT: begin
          if (wr_done) begin
`ifdef MEM_ARB_WRITE_EN
            wv <= 1'b0;
`endif
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!cons_valid) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter from N consumers onto M memory channels.
// Define MEM_ARB_WRITE_EN to build the write path.
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]  mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]  mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

  localparam int IW = idx_w(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] req;
  logic [NUM_CONSUMERS-1:0] wr_rdy;
  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            rr_next;

  logic [NUM_CHANNELS-1:0]  ch_idle;
  logic [NUM_CHANNELS-1:0]  ch_write;
  logic [NUM_CHANNELS-1:0]  grant;
  logic [NUM_CHANNELS-1:0]  gnt_write;
  logic [NUM_CHANNELS-1:0]  rd_done;
  logic [NUM_CHANNELS-1:0]  wr_done;
  logic [NUM_CHANNELS-1:0]  rel;
  logic [NUM_CHANNELS-1:0]  cons_valid;
  logic [IW-1:0]            gnt_idx  [NUM_CHANNELS];
  logic [IW-1:0]            cur_idx  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     gnt_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     gnt_data [NUM_CHANNELS];

`ifdef MEM_ARB_WRITE_EN
  localparam bit WR_EN = 1'b1;
  assign consumer_write_ready = wr_rdy;
`else
  localparam bit WR_EN = 1'b0;
  logic unused_wr;
  assign consumer_write_ready = '0;
  assign unused_wr = ^wr_rdy;
`endif

  assign req = consumer_read_valid |
               (consumer_write_valid & {NUM_CONSUMERS{WR_EN}});

  // Round-robin scan; lower channels claim first within a cycle
  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [IW-1:0]            ix;
    int                       idx;
    taken   = claimed;
    found   = 1'b0;
    ix      = '0;
    idx     = 0;
    rr_next = rr_ptr;
    grant   = '0;
    gnt_write = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      gnt_idx[ch]  = '0;
      gnt_addr[ch] = '0;
      gnt_data[ch] = '0;
      found        = 1'b0;
      if (ch_idle[ch]) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx = (int'(rr_ptr) + k) % NUM_CONSUMERS;
          ix  = IW'(idx);
          if (!found && req[ix] && !taken[ix]) begin
            found         = 1'b1;
            taken[ix]     = 1'b1;
            grant[ch]     = 1'b1;
            gnt_idx[ch]   = ix;
            gnt_write[ch] = WR_EN && !consumer_read_valid[ix];
            gnt_addr[ch]  = gnt_write[ch] ?
                            consumer_write_address[ix] :
                            consumer_read_address[ix];
            gnt_data[ch]  = consumer_write_data[ix];
            rr_next       = IW'((idx + 1) % NUM_CONSUMERS);
          end
        end
      end
    end
  end

  // Owner's valid for the op each channel is serving
  always_comb begin
    cons_valid = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      cons_valid[ch] = ch_write[ch] ?
                       consumer_write_valid[cur_idx[ch]] :
                       consumer_read_valid[cur_idx[ch]];
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    mem_arb_channel #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .IW        (IW)
    ) u_ch (
      .clk               (clk),
      .reset             (reset),
      .grant             (grant[g]),
      .grant_idx         (gnt_idx[g]),
      .grant_write       (gnt_write[g]),
      .grant_addr        (gnt_addr[g]),
      .grant_data        (gnt_data[g]),
      .cons_valid        (cons_valid[g]),
      .mem_read_ready    (mem_read_ready[g]),
      .mem_write_ready   (mem_write_ready[g]),
      .idle              (ch_idle[g]),
      .cur_idx           (cur_idx[g]),
      .cur_write         (ch_write[g]),
      .rd_done           (rd_done[g]),
      .wr_done           (wr_done[g]),
      .release_pulse     (rel[g]),
      .mem_read_valid    (mem_read_valid[g]),
      .mem_read_address  (mem_read_address[g]),
      .mem_write_valid   (mem_write_valid[g]),
      .mem_write_address (mem_write_address[g]),
      .mem_write_data    (mem_write_data[g])
    );
  end

  // Claim mask, rr pointer and per-consumer response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      claimed             <= '0;
      rr_ptr              <= '0;
      consumer_read_ready <= '0;
      wr_rdy              <= '0;
      for (int c = 0; c < NUM_CONSUMERS; c++)
        consumer_read_data[c] <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (grant[ch]) claimed[gnt_idx[ch]] <= 1'b1;
        if (rd_done[ch]) begin
          consumer_read_ready[cur_idx[ch]] <= 1'b1;
          consumer_read_data[cur_idx[ch]]  <= mem_read_data[ch];
        end
        if (wr_done[ch]) wr_rdy[cur_idx[ch]] <= 1'b1;
        if (rel[ch]) begin
          claimed[cur_idx[ch]]             <= 1'b0;
          consumer_read_ready[cur_idx[ch]] <= 1'b0;
          wr_rdy[cur_idx[ch]]              <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_channel_arbiter;

  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 8;
  localparam int NM = 4;
`ifdef MEM_ARB_WRITE_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0] crv, cwv, crr, cwr;
  logic [AB-1:0] cra [NC];
  logic [AB-1:0] cwa [NC];
  logic [DB-1:0] cwd [NC];
  logic [DB-1:0] crd [NC];
  logic [NM-1:0] mrv, mrr, mwv, mwr;
  logic [AB-1:0] mra [NM];
  logic [AB-1:0] mwa [NM];
  logic [DB-1:0] mrd [NM];
  logic [DB-1:0] mwd [NM];

  always #5 clk = ~clk;

  mem_channel_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB),
    .NUM_CONSUMERS(NC), .NUM_CHANNELS(NM)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---- transaction-level reference model ----
  // channel: owner consumer (-1 = free), waiting for memory or for release
  int            m_own  [NM];
  bit            m_wait [NM];
  bit            m_wr   [NM];
  logic [AB-1:0] m_addr [NM];
  logic [DB-1:0] m_wdat [NM];
  bit            m_claim[NC];
  bit            m_rrdy [NC];
  bit            m_wrdy [NC];
  logic [DB-1:0] m_rdat [NC];
  int            m_ptr;

  always @(posedge clk) begin : model
    int  was_own [NM];
    bit  was_wait[NM];
    int  c, last, base;
    bit  got;
    if (reset) begin
      m_ptr = 0;
      for (int i = 0; i < NM; i++) begin
        m_own[i] = -1; m_wait[i] = 0; m_wr[i] = 0;
      end
      for (int i = 0; i < NC; i++) begin
        m_claim[i] = 0; m_rrdy[i] = 0; m_wrdy[i] = 0; m_rdat[i] = '0;
      end
    end else begin
      for (int i = 0; i < NM; i++) begin
        was_own[i] = m_own[i]; was_wait[i] = m_wait[i];
      end
      base = m_ptr;
      last = -1;
      for (int ch = 0; ch < NM; ch++) begin
        if (was_own[ch] < 0) begin
          got = 0;
          for (int k = 0; k < NC; k++) begin
            c = (base + k) % NC;
            if (!got && !m_claim[c] && (crv[c] || (WR && cwv[c]))) begin
              got = 1; last = c; m_claim[c] = 1;
              m_own[ch] = c; m_wait[ch] = 1;
              m_wr[ch] = !crv[c];
              m_addr[ch] = m_wr[ch] ? cwa[c] : cra[c];
              m_wdat[ch] = cwd[c];
            end
          end
        end
      end
      if (last >= 0) m_ptr = (last + 1) % NC;
      for (int ch = 0; ch < NM; ch++) begin
        c = was_own[ch];
        if (c >= 0 && was_wait[ch]) begin
          if (!m_wr[ch] && mrr[ch]) begin
            m_rrdy[c] = 1; m_rdat[c] = mrd[ch]; m_wait[ch] = 0;
          end else if (m_wr[ch] && mwr[ch]) begin
            m_wrdy[c] = 1; m_wait[ch] = 0;
          end
        end else if (c >= 0) begin
          if (!(m_wr[ch] ? cwv[c] : crv[c])) begin
            m_rrdy[c] = 0; m_wrdy[c] = 0; m_claim[c] = 0;
            m_own[ch] = -1;
          end
        end
      end
    end
  end

  // ---- per-cycle comparison against the model ----
  bit checking = 0;
  always @(negedge clk) begin
    bit ev;
    if (checking) begin
      for (int ch = 0; ch < NM; ch++) begin
        ev = m_own[ch] >= 0 && m_wait[ch] && !m_wr[ch];
        chk($sformatf("mrv[%0d]", ch), 32'(mrv[ch]), 32'(ev));
        if (ev) chk($sformatf("mra[%0d]", ch), 32'(mra[ch]), 32'(m_addr[ch]));
        ev = m_own[ch] >= 0 && m_wait[ch] && m_wr[ch];
        chk($sformatf("mwv[%0d]", ch), 32'(mwv[ch]), 32'(ev));
        if (ev) begin
          chk($sformatf("mwa[%0d]", ch), 32'(mwa[ch]), 32'(m_addr[ch]));
          chk($sformatf("mwd[%0d]", ch), 32'(mwd[ch]), 32'(m_wdat[ch]));
        end
      end
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("crr[%0d]", c), 32'(crr[c]), 32'(m_rrdy[c]));
        chk($sformatf("cwr[%0d]", c), 32'(cwr[c]), 32'(m_wrdy[c]));
        chk($sformatf("crd[%0d]", c), 32'(crd[c]), 32'(m_rdat[c]));
      end
    end
  end

  // ---- random protocol agents ----
  bit auto = 0;
  int rcnt [NM];
  int wcnt [NM];
  always @(negedge clk) begin
    int r;
    if (auto) begin
      for (int c = 0; c < NC; c++) begin
        if (crv[c] || cwv[c]) begin
          if (crr[c] || cwr[c] || (!WR && !crv[c])) begin
            if ($urandom_range(0, 1) == 1) begin
              crv[c] = 0; cwv[c] = 0;
            end
          end
        end else if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 3);
          crv[c] = (r != 1);
          cwv[c] = (r != 0);
          cra[c] = AB'($urandom);
          cwa[c] = AB'($urandom);
          cwd[c] = DB'($urandom);
        end
      end
      for (int ch = 0; ch < NM; ch++) begin
        if (mrr[ch]) mrr[ch] = 0;
        else if (mrv[ch]) begin
          if (rcnt[ch] == 0) begin
            mrr[ch] = 1; mrd[ch] = DB'($urandom);
            rcnt[ch] = $urandom_range(0, 3);
          end else rcnt[ch]--;
        end
        if (mwr[ch]) mwr[ch] = 0;
        else if (mwv[ch]) begin
          if (wcnt[ch] == 0) begin
            mwr[ch] = 1;
            wcnt[ch] = $urandom_range(0, 3);
          end else wcnt[ch]--;
        end
      end
    end
  end

  task automatic clear_inputs();
    crv = '0; cwv = '0; mrr = '0; mwr = '0;
    for (int c = 0; c < NC; c++) begin
      cra[c] = '0; cwa[c] = '0; cwd[c] = '0;
    end
    for (int ch = 0; ch < NM; ch++) begin
      mrd[ch] = '0; rcnt[ch] = 1; wcnt[ch] = 2;
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1 checking = 1;
    @(negedge clk);
    // reset state
    chk("rst_crr", 32'(crr), 0);
    chk("rst_mrv", 32'(mrv), 0);
    chk("rst_mwv", 32'(mwv), 0);
    chk("rst_crd2", 32'(crd[2]), 0);
    reset = 1'b0;

    // consumer 2 reads 0x10, memory answers 0xAB two cycles later
    cra[2] = 8'h10; crv[2] = 1;
    @(negedge clk);
    chk("t1_mrv", 32'(mrv), 32'h1);
    chk("t1_mra", 32'(mra[0]), 32'h10);
    @(negedge clk);
    mrr[0] = 1; mrd[0] = 8'hAB;
    @(negedge clk);
    mrr[0] = 0;
    chk("t1_crr", 32'(crr), 32'h04);
    chk("t1_crd", 32'(crd[2]), 32'hAB);
    chk("t1_mrv_drop", 32'(mrv), 0);
    crv[2] = 0;
    @(negedge clk);
    chk("t1_crr_clr", 32'(crr), 0);
    chk("t1_crd_hold", 32'(crd[2]), 32'hAB);

    // fresh pointer, then all eight read at once
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < NC; c++) begin
      cra[c] = AB'(8'h20 + c); crv[c] = 1;
    end
    @(negedge clk);
    chk("t2_mrv_a", 32'(mrv), 32'hF);
    for (int ch = 0; ch < NM; ch++) begin
      chk("t2_mra_a", 32'(mra[ch]), 32'(8'h20 + ch));
      mrd[ch] = DB'(8'h90 + ch);
    end
    mrr = '1;
    @(negedge clk);
    mrr = '0;
    chk("t2_crr", 32'(crr), 32'h0F);
    crv[3:0] = '0;
    @(negedge clk);
    chk("t2_crr_clr", 32'(crr), 0);
    @(negedge clk);
    chk("t2_mrv_b", 32'(mrv), 32'hF);
    for (int ch = 0; ch < NM; ch++)
      chk("t2_mra_b", 32'(mra[ch]), 32'(8'h24 + ch));

    // reset while every channel is waiting on memory
    reset = 1; crv = '0;
    @(negedge clk);
    chk("t5_mrv", 32'(mrv), 0);
    chk("t5_crr", 32'(crr), 0);
    chk("t5_crd0", 32'(crd[0]), 0);
    chk("t5_mra0", 32'(mra[0]), 0);
    reset = 0;
    cra[6] = 8'h55; crv[6] = 1;
    @(negedge clk);
    chk("t5_mrv_new", 32'(mrv), 32'h1);
    chk("t5_mra_new", 32'(mra[0]), 32'h55);
    mrr[0] = 1; mrd[0] = 8'h3C;
    @(negedge clk);
    mrr[0] = 0;
    chk("t5_crr_new", 32'(crr), 32'h40);
    chk("t5_crd_new", 32'(crd[6]), 32'h3C);
    crv[6] = 0;
    @(negedge clk);

    // consumer 1 writes 0x7E to 0x33
    cwa[1] = 8'h33; cwd[1] = 8'h7E; cwv[1] = 1;
    @(negedge clk);
    chk("t4_mwv", 32'(mwv), WR ? 32'h1 : 32'h0);
    chk("t4_mrv", 32'(mrv), 0);
    if (WR) begin
      chk("t4_mwa", 32'(mwa[0]), 32'h33);
      chk("t4_mwd", 32'(mwd[0]), 32'h7E);
    end
    mwr[0] = WR;
    @(negedge clk);
    mwr[0] = 0;
    chk("t4_cwr", 32'(cwr), WR ? 32'h02 : 32'h0);
    cwv[1] = 0;
    @(negedge clk);
    chk("t4_cwr_clr", 32'(cwr), 0);

    // randomized traffic with occasional mid-stream reset
    clear_inputs();
    @(negedge clk);
    auto = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = (i % 700 == 350);
    end
    auto = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
